// File: rtl/k_sort_reader.sv
// k_sort_reader: snapshots the top-K sorted slots on load and streams occupied slots in rank order with an order check
module k_sort_reader #(
  parameter int WIDTH = 32,
  parameter int K = 20,
  parameter int RW = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [K*WIDTH-1:0] sorted_value,
  input  logic [K*WIDTH-1:0] sorted_index,
  input  logic [K-1:0]     sorted_valid,
  input  logic             asce,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [WIDTH-1:0] out_index,
  output logic [RW-1:0]    out_rank,
  output logic             out_last,
  output logic             done,
  output logic [RW-1:0]    count,
  output logic             order_err
);
  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state, state_n;
  logic [K*WIDTH-1:0] val_q, idx_q;
  logic [K-1:0] pend, sel;
  logic [WIDTH-1:0] prev;
  logic [RW-1:0] pop;
  logic asce_q, accept, xfer, bad;
  assign accept = state == IDLE && load;
  assign xfer = out_valid && out_ready;
  assign bad = out_rank != '0 && (asce_q ? out_value < prev : out_value > prev);
  always_comb begin
    pop = '0;
    for (int i = 0; i < K; i++) pop = pop + RW'(sorted_valid[i]);
  end
  always_comb begin
    sel = pend & (~pend + K'(1));
    out_value = '0;
    out_index = '0;
    for (int i = 0; i < K; i++) begin
      out_value = out_value | (val_q[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
      out_index = out_index | (idx_q[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE   ? (load ? (pop != '0 ? STREAM : FINISH) : IDLE) :
              state == STREAM ? (xfer && out_last ? FINISH : STREAM) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    out_valid = state == STREAM;
    done = state == FINISH;
    out_last = pend != '0 && (pend & (pend - K'(1))) == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      idx_q <= '0;
      pend <= '0;
      asce_q <= 1'b0;
      prev <= '0;
      out_rank <= '0;
      count <= '0;
      order_err <= 1'b0;
    end else if (accept) begin
      val_q <= sorted_value;
      idx_q <= sorted_index;
      pend <= sorted_valid;
      asce_q <= asce;
      prev <= '0;
      out_rank <= '0;
      count <= pop;
      order_err <= 1'b0;
    end else if (xfer) begin
      pend <= pend & ~sel;
      prev <= out_value;
      out_rank <= out_rank + RW'(1);
      order_err <= order_err | bad;
    end
  end
endmodule

// File: tb/tb_k_sort_reader.sv
// tb_k_sort_reader: table-driven load/stream vectors plus a mid-stream reset sequence for k_sort_reader
module tb_k_sort_reader;
  localparam int W = 32;
  localparam int K = 4;
  localparam int RW = $clog2(K + 1);
  logic clk = 1'b0;
  logic rst, load, asce, out_ready, busy, out_valid, out_last, done, order_err;
  logic [K*W-1:0] sorted_value, sorted_index;
  logic [K-1:0] sorted_valid;
  logic [W-1:0] out_value, out_index;
  logic [RW-1:0] out_rank, count;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [K-1:0] valid;
    logic [K*W-1:0] v, ix, ev, ei;
    logic asce;
    bit stall;
    bit mid_load;
    int n;
    int done_cyc;
    int err_cyc;
  } vec_t;
  vec_t vecs[6];
  k_sort_reader #(.WIDTH(W), .K(K)) dut (
    .clk(clk), .rst(rst), .load(load),
    .sorted_value(sorted_value), .sorted_index(sorted_index), .sorted_valid(sorted_valid),
    .asce(asce), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_index(out_index), .out_rank(out_rank), .out_last(out_last),
    .done(done), .count(count), .order_err(order_err)
  );
  always #5 clk = ~clk;
  function automatic logic [K*W-1:0] p4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input int t);
    vec_t c;
    int k, done_n, done_at, err_at;
    c = vecs[t];
    k = 0;
    done_n = 0;
    done_at = -1;
    err_at = -1;
    sorted_valid = c.valid;
    sorted_value = c.v;
    sorted_index = c.ix;
    asce = c.asce;
    out_ready = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk($sformatf("busy_after_load_%0d", t), busy, 1);
    chk($sformatf("err_clear_on_load_%0d", t), order_err, 0);
    chk($sformatf("count_%0d", t), count, c.n);
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = c.stall ? (cyc % 3 == 0) : 1'b1;
      if (out_valid) begin
        if (k < c.n)
          chk($sformatf("entry_%0d_%0d", t, k), {out_value, out_index, out_rank, out_last},
              {c.ev[k*W +: W], c.ei[k*W +: W], RW'(k), k == c.n - 1});
        else
          chk($sformatf("extra_entry_%0d", t), out_valid, 0);
        if (out_ready) k++;
      end
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = cyc;
      end
      if (order_err && err_at < 0) err_at = cyc;
      if (c.mid_load && cyc == 2) begin
        load = 1'b1;
        sorted_valid = '0;
        sorted_value = '1;
        asce = ~c.asce;
      end else begin
        load = 1'b0;
        sorted_valid = c.valid;
        sorted_value = c.v;
        asce = c.asce;
      end
      tick();
    end
    chk($sformatf("entries_seen_%0d", t), k, c.n);
    chk($sformatf("done_pulses_%0d", t), done_n, 1);
    chk($sformatf("done_cycle_%0d", t), done_at, c.done_cyc);
    chk($sformatf("err_rise_cycle_%0d", t), err_at, c.err_cyc);
    chk($sformatf("err_final_%0d", t), order_err, c.err_cyc >= 0);
    chk($sformatf("idle_after_%0d", t), {busy, out_valid}, 0);
    chk($sformatf("count_hold_%0d", t), count, c.n);
  endtask
  initial begin
    vecs[0] = '{4'b1111, p4(3, 5, 5, 9), p4(10, 11, 12, 13), p4(3, 5, 5, 9), p4(10, 11, 12, 13), 1'b1, 0, 0, 4, 4, -1};
    vecs[1] = '{4'b0101, p4(7, 99, 2, 50), p4(20, 21, 22, 23), p4(7, 2, 0, 0), p4(20, 22, 0, 0), 1'b0, 0, 0, 2, 2, -1};
    vecs[2] = '{4'b0000, p4(8, 1, 8, 1), p4(1, 2, 3, 4), '0, '0, 1'b1, 0, 0, 0, 0, -1};
    vecs[3] = '{4'b1111, p4(1, 2, 3, 4), p4(30, 31, 32, 33), p4(1, 2, 3, 4), p4(30, 31, 32, 33), 1'b1, 1, 1, 4, 10, -1};
    vecs[4] = '{4'b0111, p4(4, 2, 6, 0), p4(40, 41, 42, 43), p4(4, 2, 6, 0), p4(40, 41, 42, 0), 1'b1, 0, 0, 3, 3, 2};
    vecs[5] = '{4'b1011, p4(9, 9, 100, 1), p4(50, 51, 52, 53), p4(9, 9, 1, 0), p4(50, 51, 53, 0), 1'b0, 0, 0, 3, 3, -1};
    rst = 1'b1;
    load = 1'b0;
    asce = 1'b0;
    out_ready = 1'b0;
    sorted_valid = '0;
    sorted_value = '0;
    sorted_index = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", {busy, out_valid, out_last, done, order_err, out_value, out_index, out_rank, count}, 0);
    for (int t = 0; t < 6; t++) run_vec(t);
    sorted_valid = vecs[0].valid;
    sorted_value = vecs[0].v;
    sorted_index = vecs[0].ix;
    asce = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("pre_reset_entry", {out_valid, out_value, out_rank}, {1'b1, 32'd5, RW'(2)});
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_reset_state", {out_valid, busy, done, out_last, out_rank, count}, 0);
    begin
      logic stray;
      stray = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
        stray = stray | done | out_valid;
        tick();
      end
      chk("no_done_after_reset", stray, 0);
    end
    run_vec(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
